// File: rtl/flag_ctx_pkg.sv
// Shared flag indices, default masks and stack helpers for the flag context register.
// Build option: FLAG_CTX_PARITY_EN adds a parity bit to every saved stack entry.
package flag_ctx_pkg;

    localparam int NFLAGS_DEF = 13;

    localparam int ZF_BIT   = 0;
    localparam int SF_BIT   = 1;
    localparam int OF_BIT   = 2;
    localparam int UF_BIT   = 3;
    localparam int CFFW_BIT = 4;
    localparam int CFHL_BIT = 5;
    localparam int CFHH_BIT = 6;
    localparam int DF_BIT   = 7;
    localparam int HWF_BIT  = 8;
    localparam int SRF_BIT  = 9;
    localparam int MVF_BIT  = 10;
    localparam int MCF_BIT  = 11;
    localparam int TF_BIT   = 12;

    // df, mvf, mcf and tf accumulate and are the interrupt sources by default
    localparam logic [NFLAGS_DEF-1:0] STICKY_MASK_DEF = 13'h1C80;
    localparam logic [NFLAGS_DEF-1:0] IRQ_MASK_DEF    = 13'h1C80;

    typedef enum logic [1:0] {
        STK_IDLE = 2'b00,
        STK_PUSH = 2'b01,
        STK_POP  = 2'b10
    } stk_op_e;

    // Even-parity bit: makes the total number of ones (data plus bit) even
    function automatic logic flag_parity(input logic [31:0] v);
        return ^v;
    endfunction

    // A simultaneous push and pop cancel out and leave the stack alone
    function automatic stk_op_e stk_decode(input logic push, input logic pop);
        stk_op_e op;
        case ({pop, push})
            2'b01:   op = STK_PUSH;
            2'b10:   op = STK_POP;
            default: op = STK_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/flag_ctx_reg_if.sv
// Datapath/control-side bundle of the flag context register.
// Build option: FLAG_CTX_PARITY_EN adds the par_inj fault-injection input.
interface flag_ctx_reg_if #(
    parameter int NFLAGS = 13,
    parameter int DEPTH  = 4
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic [NFLAGS-1:0] flag_in;
    logic              flag_we;
    logic              sw_we;
    logic [NFLAGS-1:0] sw_wdata;
    logic [NFLAGS-1:0] sw_clr;
    logic              push;
    logic              pop;
    logic              irq_ack;
    logic              err_clr;
`ifdef FLAG_CTX_PARITY_EN
    logic              par_inj;
`endif

    logic [NFLAGS-1:0] flags_out;
    logic [SPW-1:0]    sp_out;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;
    logic              irq;

    modport master (
`ifdef FLAG_CTX_PARITY_EN
        output par_inj,
`endif
        output flag_in, flag_we, sw_we, sw_wdata, sw_clr, push, pop, irq_ack, err_clr,
        input  flags_out, sp_out, stack_full, stack_empty, stack_err, irq
    );

    modport slave (
`ifdef FLAG_CTX_PARITY_EN
        input  par_inj,
`endif
        input  flag_in, flag_we, sw_we, sw_wdata, sw_clr, push, pop, irq_ack, err_clr,
        output flags_out, sp_out, stack_full, stack_empty, stack_err, irq
    );

endinterface

// File: rtl/flag_ctx_reg_lifo.sv
// Save stack for flag contexts: DEPTH x WIDTH LIFO with registered occupancy,
// full/empty flags and a same-cycle overflow/underflow strobe.
module flag_lifo
    import flag_ctx_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 13,
    localparam int SPW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [SPW-1:0]   sp,
    output logic             full,
    output logic             empty,
    output logic             pop_ok,
    output logic             err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SPW-1:0]   r_sp;
    logic             r_full;
    logic             r_empty;

    stk_op_e          w_op;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_err;
    logic [SPW-1:0]   w_sp_nxt;
    logic [IW-1:0]    w_wr_idx;
    logic [IW-1:0]    w_rd_idx;

    assign w_op = stk_decode(push, pop);

    // Accept the operation only when it cannot over- or underflow
    always_comb begin
        w_do_push = 1'b0;
        w_do_pop  = 1'b0;
        w_err     = 1'b0;
        case (w_op)
            STK_PUSH: begin
                if (r_full) begin
                    w_err = 1'b1;
                end else begin
                    w_do_push = 1'b1;
                end
            end
            STK_POP: begin
                if (r_empty) begin
                    w_err = 1'b1;
                end else begin
                    w_do_pop = 1'b1;
                end
            end
            default: begin
                w_err = 1'b0;
            end
        endcase
    end

    // Next occupancy, saturating by construction of the accept logic
    always_comb begin
        w_sp_nxt = r_sp;
        if (w_do_push) begin
            w_sp_nxt = r_sp + SPW'(1);
        end else if (w_do_pop) begin
            w_sp_nxt = r_sp - SPW'(1);
        end else begin
            w_sp_nxt = r_sp;
        end
    end

    assign w_wr_idx = IW'(r_sp);
    assign w_rd_idx = r_empty ? {IW{1'b0}} : IW'(r_sp - SPW'(1));

    // Occupancy plus registered full/empty status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp    <= {SPW{1'b0}};
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_sp    <= w_sp_nxt;
            r_full  <= (w_sp_nxt == SPW'(DEPTH));
            r_empty <= (w_sp_nxt == {SPW{1'b0}});
        end
    end

    // Entry storage; contents are only read after being written
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= wdata;
        end
    end

    assign rdata  = r_mem[w_rd_idx];
    assign sp     = r_sp;
    assign full   = r_full;
    assign empty  = r_empty;
    assign pop_ok = w_do_pop;
    assign err    = w_err;

endmodule

// File: rtl/flag_ctx_reg.sv
// Processor status-flag register with sticky bits, software access, a context
// save stack and a masked-edge interrupt. Build option: FLAG_CTX_PARITY_EN.
module flag_ctx_reg
    import flag_ctx_pkg::*;
#(
    parameter int                NFLAGS      = NFLAGS_DEF,
    parameter logic [NFLAGS-1:0] STICKY_MASK = NFLAGS'(STICKY_MASK_DEF),
    parameter logic [NFLAGS-1:0] IRQ_MASK    = NFLAGS'(IRQ_MASK_DEF),
    parameter int                DEPTH       = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    flag_ctx_reg_if.slave  bus
);

    localparam int SPW = $clog2(DEPTH + 1);
`ifdef FLAG_CTX_PARITY_EN
    localparam int EW  = NFLAGS + 1;
`else
    localparam int EW  = NFLAGS;
`endif

    logic [NFLAGS-1:0] r_flags;
    logic              r_err;
    logic              r_irq;

    logic [EW-1:0]     w_entry;
    logic [EW-1:0]     w_top;
    logic [SPW-1:0]    w_sp;
    logic              w_full;
    logic              w_empty;
    logic              w_pop_ok;
    logic              w_stk_err;
    logic              w_top_ok;
    logic              w_restore;
    logic              w_err_new;
    logic              w_rise;
    logic [NFLAGS-1:0] w_base;
    logic [NFLAGS-1:0] w_next;

`ifdef FLAG_CTX_PARITY_EN
    // par_inj flips the stored parity so the restore path can be exercised
    assign w_entry  = {flag_parity(32'(r_flags)) ^ bus.par_inj, r_flags};
    assign w_top_ok = (flag_parity(32'(w_top[NFLAGS-1:0])) == w_top[NFLAGS]);
`else
    assign w_entry  = r_flags;
    assign w_top_ok = 1'b1;
`endif

    flag_lifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_lifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (bus.push),
        .pop    (bus.pop),
        .wdata  (w_entry),
        .rdata  (w_top),
        .sp     (w_sp),
        .full   (w_full),
        .empty  (w_empty),
        .pop_ok (w_pop_ok),
        .err    (w_stk_err)
    );

    // A popped entry with bad parity is discarded: sp still drops but flags are not restored
    assign w_restore = w_pop_ok & w_top_ok;
    assign w_err_new = w_stk_err | (w_pop_ok & ~w_top_ok);

    // Flag next state: restore, else software write / datapath update / hold, then clear mask
    always_comb begin
        w_base = r_flags;
        w_next = r_flags;
        if (bus.sw_we) begin
            w_base = bus.sw_wdata;
        end else if (bus.flag_we) begin
            w_base = (r_flags & STICKY_MASK) | bus.flag_in;
        end else begin
            w_base = r_flags;
        end
        if (w_restore) begin
            w_next = w_top[NFLAGS-1:0];
        end else begin
            w_next = w_base & ~bus.sw_clr;
        end
    end

    assign w_rise = |(w_next & ~r_flags & IRQ_MASK);

    // Flag register, sticky stack error and pending interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= {NFLAGS{1'b0}};
            r_err   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_flags <= w_next;
            if (w_err_new) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end
            if (w_rise) begin
                r_irq <= 1'b1;
            end else if (bus.irq_ack) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign bus.flags_out   = r_flags;
    assign bus.sp_out      = w_sp;
    assign bus.stack_full  = w_full;
    assign bus.stack_empty = w_empty;
    assign bus.stack_err   = r_err;
    assign bus.irq         = r_irq;

endmodule

// File: doc/flag_ctx_reg.md
Name: flag_ctx_reg

Overview:
- Parametrised successor to the 13-bit processor status-flag register.
- Adds:
  - per-cycle update enable;
  - sticky (accumulating) flag bits;
  - software write and write-1-to-clear access;
  - a LIFO save/restore stack for context switches on trap or interrupt entry and return;
  - a masked-flag interrupt request.
- Sits between the ALU/memory-unit flag outputs and the control unit / trap handler.

Parameters:
- NFLAGS, 13: number of flag bits. Bit order: zf, sf, of, uf, cffw, cfhl, cfhh, df, hwf, srf, mvf, mcf, tf (bit 0 to bit 12).
- STICKY_MASK, 13'h1C80: bits that OR-accumulate instead of overwrite. Default covers df, mvf, mcf, tf.
- IRQ_MASK, 13'h1C80: bits whose 0->1 transition raises irq.
- DEPTH, 4: save-stack entries (>=1).

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- flag_in, input, NFLAGS: new flag values from the datapath.
- flag_we, input, 1: apply flag_in this cycle.
- sw_we, input, 1: software write of sw_wdata.
- sw_wdata, input, NFLAGS: software write data.
- sw_clr, input, NFLAGS: write-1-to-clear mask; also bit-clears the flags.
- push, input, 1: save current flags to stack.
- pop, input, 1: restore flags from stack top.
- irq_ack, input, 1: clear pending interrupt.
- err_clr, input, 1: clear stack_err.
- flags_out, output, NFLAGS: current flag register.
- sp_out, output, clog2(DEPTH+1): stack occupancy.
- stack_full, output, 1: sp_out==DEPTH.
- stack_empty, output, 1: sp_out==0.
- stack_err, output, 1: sticky overflow/underflow (parity) error.
- irq, output, 1: interrupt pending.

Behaviour:
- Reset: flags_out=0, sp_out=0, stack_err=0, irq=0. Stack contents are undefined; they are not read before being written.
- All outputs are registered. The update is visible the cycle after the inputs are sampled (1-cycle latency).
- Flag next-state priority, highest first:
  1. Valid pop: flags <= stack[sp-1]. flag_we, sw_we and sw_clr are ignored that cycle.
  2. sw_we: flags <= sw_wdata.
  3. flag_we: bit i <= STICKY_MASK[i] ? (flags[i] | flag_in[i]) : flag_in[i].
  4. Otherwise hold.
- sw_clr is applied after rule 2 or 3 and before the register (flags & ~sw_clr). It has no effect when rule 1 fires.
- Push, valid when !stack_full:
  - stack[sp] <= current flags_out (pre-update value); sp++.
  - The flag register updates normally in the same cycle.
- Pop, valid when !stack_empty: sp--.
- push && pop in the same cycle: no stack operation and no error; flags follow rules 2-4.
- Push when full, or pop when empty:
  - The operation is ignored and sp is unchanged.
  - stack_err <= 1. The flag rules still apply, excluding rule 1.
- stack_err clears on err_clr. A new error in the same cycle as err_clr wins (stays 1).
- irq:
  - Set when any bit of (next_flags & ~flags_out & IRQ_MASK) is 1, including rising edges caused by pop or sw_we.
  - Cleared by irq_ack. Set wins over a simultaneous irq_ack.
- No wrap-around: sp saturates at 0 and DEPTH.

Optional Feature:
- Macro FLAG_CTX_PARITY_EN.
- With the macro:
  - Each stack entry stores an extra even-parity bit.
  - Extra input par_inj (1 bit) inverts the stored parity on that push.
  - On a pop whose entry fails the parity check: sp still decrements, flags are NOT restored (rules 2-4 apply instead), and stack_err <= 1.
- Without the macro: no parity storage, no par_inj port, and pop always restores.

Decomposition:
- Package flag_ctx_pkg:
  - flag index constants ZF_BIT=0 ... TF_BIT=12;
  - NFLAGS_DEF=13;
  - STICKY_MASK_DEF and IRQ_MASK_DEF;
  - function flag_parity.
- Sub-module flag_lifo:
  - parametrised DEPTH×WIDTH LIFO with push/pop, sp, full, empty and an overflow/underflow strobe;
  - instantiated once in flag_ctx_reg.

Test Plan:
- Reset mid-operation:
  - Stimulus: push twice (sp=2), flags=13'h0005, then assert rst_n=0 asynchronously.
  - Required: flags_out=0, sp_out=0, stack_empty=1, irq=0 immediately, without waiting for a clock edge.
- Sticky accumulation:
  - Stimulus: flag_we with flag_in=13'h0080 (df), then flag_we with flag_in=13'h0001.
  - Required: flags_out=13'h0081. Then sw_clr=13'h0080 gives 13'h0001.
- Context save/restore:
  - Stimulus: flags=13'h0003; push together with flag_we flag_in=13'h0004.
  - Required: flags=13'h0004, sp=1. Then pop gives flags=13'h0003, sp=0.
- Overflow/underflow:
  - Stimulus: DEPTH=4; five pushes.
  - Required: sp=4, stack_full=1, stack_err=1 after the 5th push.
  - Then err_clr clears stack_err. Five pops give sp=0 and stack_err=1 again.
- irq edge/ack race:
  - Stimulus: flag_we flag_in=13'h1000 (tf).
  - Required: irq=1 next cycle.
  - Then sw_we 0 then flag_we 13'h1000 with irq_ack in the same cycle: irq stays 1.
- Parity (FLAG_CTX_PARITY_EN):
  - Stimulus: push with par_inj=1 while flags=13'h0002, set flags=13'h0010, then pop.
  - Required: flags stays 13'h0010, sp=0, stack_err=1.
